regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file (read ports Ra/Rb, write port Wr/We/D, r0 hard-wired to zero) between two writeback requesters: requester 0 is ALU writeback, requester 1 is load writeback.
- Each requester has a one-entry holding slot. A round-robin arbiter drains the slots into a registered write stage that drives Wr/We/D.
- Reports read-after-write hazards for the two read addresses against writes that are still in flight.

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 41 ++++
 rtl/regfile_wb_arbiter_slot.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the slot entry layout and the address-match helper used for hazards.
package rf_ctrl_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int DW_DEFAULT = 32;
  localparam int NREG       = 32;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [DW_DEFAULT-1:0] data;
  } wb_entry_t;

  localparam logic [AW_DEFAULT-1:0] REG_ZERO = 5'd0;

  function automatic logic addr_hit(input logic v,
                                    input logic [AW_DEFAULT-1:0] a,
                                    input logic [AW_DEFAULT-1:0] rd);
    return v && (a == rd);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and hazard signals of the arbiter.
// The master side is the requester/pipeline, the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          rf_we;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_d;
  logic [AW-1:0] rd_ra;
  logic [AW-1:0] rd_rb;
  logic          hazard_a;
  logic          hazard_b;
  logic          idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rd_ra, rd_rb,
    input  req0_ready, req1_ready,
    input  rf_we, rf_wr, rf_d,
    input  hazard_a, hazard_b, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rd_ra, rd_rb,
    output req0_ready, req1_ready,
    output rf_we, rf_wr, rf_d,
    output hazard_a, hazard_b, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry holding slot for a writeback requester.
// ready is its own flop so it never depends combinationally on valid.
module wb_slot
  import rf_ctrl_pkg::*;
(
  input  logic      Clk,
  input  logic      Clrn,
  input  logic      valid,
  input  wb_entry_t entry,
  input  logic      grant,
  output logic      ready,
  output logic      slot_v,
  output wb_entry_t slot_entry
);

  logic      slot_v_r;
  logic      ready_r;
  logic      accept_s;
  logic      slot_v_nxt_s;
  wb_entry_t entry_r;

  assign accept_s = valid && ready_r;

  // Next occupancy: accept fills, grant frees (never both on one edge).
  always_comb begin
    slot_v_nxt_s = slot_v_r;
    if (accept_s) begin
      slot_v_nxt_s = 1'b1;
    end else if (grant) begin
      slot_v_nxt_s = 1'b0;
    end else begin
      slot_v_nxt_s = slot_v_r;
    end
  end

  // Slot state, ready flag and captured entry.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      slot_v_r <= 1'b0;
      ready_r  <= 1'b1;
      entry_r  <= '0;
    end else begin
      slot_v_r <= slot_v_nxt_s;
      ready_r  <= ~slot_v_nxt_s;
      if (accept_s) begin
        entry_r <= entry;
      end
    end
  end

  assign ready      = ready_r;
  assign slot_v     = slot_v_r;
  assign slot_entry = entry_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and load
// writeback, with a registered write stage and read-after-write hazard flags.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                Clk,
  input  logic                Clrn,
  regfile_wb_arbiter_if.slave bus
);

  wb_entry_t     in0_s, in1_s, e0_s, e1_s, gnt_entry_s;
  logic          slot0_v_s, slot1_v_s;
  logic          gnt0_s, gnt1_s, any_gnt_s, stage_we_s;
  logic          rr_ptr_r;
  logic          rf_we_r;
  logic [AW-1:0] rf_wr_r;
  logic [DW-1:0] rf_d_r;

  assign in0_s = {bus.req0_addr, bus.req0_data};
  assign in1_s = {bus.req1_addr, bus.req1_data};

  wb_slot u_slot0 (
    .Clk(Clk), .Clrn(Clrn), .valid(bus.req0_valid), .entry(in0_s),
    .grant(gnt0_s), .ready(bus.req0_ready), .slot_v(slot0_v_s), .slot_entry(e0_s)
  );

  wb_slot u_slot1 (
    .Clk(Clk), .Clrn(Clrn), .valid(bus.req1_valid), .entry(in1_s),
    .grant(gnt1_s), .ready(bus.req1_ready), .slot_v(slot1_v_s), .slot_entry(e1_s)
  );

  // Grant selection: a lone valid slot wins, otherwise rr_ptr decides.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case ({slot1_v_s, slot0_v_s})
      2'b01:   gnt0_s = 1'b1;
      2'b10:   gnt1_s = 1'b1;
      2'b11: begin
        gnt0_s = ~rr_ptr_r;
        gnt1_s = rr_ptr_r;
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign any_gnt_s   = gnt0_s | gnt1_s;
  assign gnt_entry_s = gnt1_s ? e1_s : e0_s;
  assign stage_we_s  = any_gnt_s && !(ZERO_DISCARD && (gnt_entry_s.addr == REG_ZERO));

  // Write stage and round-robin pointer; address/data hold when nothing is granted.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      rr_ptr_r <= 1'b0;
      rf_we_r  <= 1'b0;
      rf_wr_r  <= '0;
      rf_d_r   <= '0;
    end else begin
      rf_we_r <= stage_we_s;
      if (any_gnt_s) begin
        rr_ptr_r <= gnt0_s;
        rf_wr_r  <= gnt_entry_s.addr;
        rf_d_r   <= gnt_entry_s.data;
      end
    end
  end

  assign bus.rf_we = rf_we_r;
  assign bus.rf_wr = rf_wr_r;
  assign bus.rf_d  = rf_d_r;

  // r0 reads never stall: any hit on address zero is masked.
  assign bus.hazard_a = (bus.rd_ra != REG_ZERO) &&
                        (addr_hit(slot0_v_s, e0_s.addr, bus.rd_ra) ||
                         addr_hit(slot1_v_s, e1_s.addr, bus.rd_ra) ||
                         addr_hit(rf_we_r, rf_wr_r, bus.rd_ra));
  assign bus.hazard_b = (bus.rd_rb != REG_ZERO) &&
                        (addr_hit(slot0_v_s, e0_s.addr, bus.rd_rb) ||
                         addr_hit(slot1_v_s, e1_s.addr, bus.rd_rb) ||
                         addr_hit(rf_we_r, rf_wr_r, bus.rd_rb));

  assign bus.idle = ~slot0_v_s & ~slot1_v_s & ~rf_we_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic Clk;
  logic Clrn;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.AW(5), .DW(32), .ZERO_DISCARD(1'b1)) dut (
    .Clk(Clk), .Clrn(Clrn), .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clrn = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    Clrn = 1'b1;
  endtask

  task automatic test_reset();
    Clrn = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h1234_5678;
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'h0;
    bus.rd_ra = 5'd5; bus.rd_rb = 5'd0;
    tick(); tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", bus.req0_ready); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    checks++; if (bus.rf_wr !== 5'd0 || bus.rf_d !== 32'h0) begin errors++; $display("FAIL reset_wr_d: got %0d/%h want 0/0", bus.rf_wr, bus.rf_d); end
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", bus.hazard_a); end
    Clrn = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.req0_ready !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL first_accept: got ready=%b we=%b want ready=0 we=0", bus.req0_ready, bus.rf_we); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL first_slot_hazard: got %b want 1", bus.hazard_a); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_d !== 32'h1234_5678) begin
      errors++; $display("FAIL first_write: got we=%b wr=%0d d=%h want 1/5/12345678", bus.rf_we, bus.rf_wr, bus.rf_d); end
    tick();
    checks++; if (bus.rf_we !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL first_drain: got we=%b idle=%b want 0/1", bus.rf_we, bus.idle); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.rd_ra = 5'd0; bus.rd_rb = 5'd0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_000A;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h0000_000B;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd3 || bus.rf_d !== 32'hA) begin
      errors++; $display("FAIL cont_first: got we=%b wr=%0d d=%h want 1/3/a", bus.rf_we, bus.rf_wr, bus.rf_d); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd4 || bus.rf_d !== 32'hB) begin
      errors++; $display("FAIL cont_second: got we=%b wr=%0d d=%h want 1/4/b", bus.rf_we, bus.rf_wr, bus.rf_d); end
    tick();
    // rr_ptr is back at 0: a single req0 write moves it to 1 before the rerun
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h0000_0001;
    tick();
    bus.req0_valid = 1'b0;
    tick(); tick();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_000A;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h0000_000B;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    checks++; if (bus.rf_wr !== 5'd4 || bus.rf_we !== 1'b1) begin errors++; $display("FAIL cont_rerun_first: got wr=%0d we=%b want 4/1", bus.rf_wr, bus.rf_we); end
    tick();
    checks++; if (bus.rf_wr !== 5'd3 || bus.rf_we !== 1'b1) begin errors++; $display("FAIL cont_rerun_second: got wr=%0d we=%b want 3/1", bus.rf_wr, bus.rf_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rd_ra = 5'd10; bus.rd_rb = 5'd20;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 32'h0000_0100;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd20; bus.req1_data = 32'h0000_0200;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rf_we !== 1'b0) begin
          errors++; $display("FAIL b2b_fill: got r0=%b r1=%b we=%b want 0/0/0", bus.req0_ready, bus.req1_ready, bus.rf_we); end
      end else begin
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== ((k % 2 == 0) ? 5'd10 : 5'd20)) begin
          errors++; $display("FAIL b2b_grant k=%0d: got we=%b wr=%0d want 1/%0d", k, bus.rf_we, bus.rf_wr, (k % 2 == 0) ? 10 : 20); end
        checks++; if (bus.req0_ready !== ((k % 2 == 0) ? 1'b1 : 1'b0) || bus.req1_ready !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL b2b_ready k=%0d: got r0=%b r1=%b", k, bus.req0_ready, bus.req1_ready); end
      end
      checks++; if (bus.hazard_a !== 1'b1 || bus.hazard_b !== 1'b1) begin
        errors++; $display("FAIL b2b_hazard k=%0d: got a=%b b=%b want 1/1", k, bus.hazard_a, bus.hazard_b); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd20 || bus.hazard_a !== 1'b0) begin
      errors++; $display("FAIL b2b_last: got we=%b wr=%0d ha=%b want 1/20/0", bus.rf_we, bus.rf_wr, bus.hazard_a); end
    tick();
    checks++; if (bus.idle !== 1'b1 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle: got idle=%b we=%b want 1/0", bus.idle, bus.rf_we); end
  endtask

  task automatic test_same_dest();
    do_reset();
    bus.rd_ra = 5'd7; bus.rd_rb = 5'd9;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h0000_0001;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h0000_0002;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++; if (bus.hazard_a !== 1'b1 || bus.hazard_b !== 1'b0) begin errors++; $display("FAIL same_slot_hazard: got a=%b b=%b want 1/0", bus.hazard_a, bus.hazard_b); end
    tick();
    checks++; if (bus.rf_d !== 32'h1 || bus.hazard_a !== 1'b1) begin errors++; $display("FAIL same_first: got d=%h ha=%b want 1/1", bus.rf_d, bus.hazard_a); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd7 || bus.rf_d !== 32'h2 || bus.hazard_a !== 1'b1) begin
      errors++; $display("FAIL same_last: got we=%b wr=%0d d=%h ha=%b want 1/7/2/1", bus.rf_we, bus.rf_wr, bus.rf_d, bus.hazard_a); end
    tick();
    checks++; if (bus.hazard_a !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL same_clear: got ha=%b we=%b want 0/0", bus.hazard_a, bus.rf_we); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    bus.rd_ra = 5'd0; bus.rd_rb = 5'd0;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h0000_FFFF;
    tick();
    bus.req1_valid = 1'b0;
    checks++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0 || bus.idle !== 1'b0) begin
      errors++; $display("FAIL zero_slot: got ha=%b hb=%b idle=%b want 0/0/0", bus.hazard_a, bus.hazard_b, bus.idle); end
    tick();
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_d !== 32'h0000_FFFF) begin
      errors++; $display("FAIL zero_stage: got we=%b wr=%0d d=%h want 0/0/ffff", bus.rf_we, bus.rf_wr, bus.rf_d); end
    checks++; if (bus.idle !== 1'b1 || bus.hazard_a !== 1'b0) begin errors++; $display("FAIL zero_idle: got idle=%b ha=%b want 1/0", bus.idle, bus.hazard_a); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.rd_ra = 5'd12; bus.rd_rb = 5'd13;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd13; bus.req1_data = 32'h0000_0066;
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd12; bus.req0_data = 32'h0000_0055;
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.req0_ready !== 1'b0 || bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd13) begin
      errors++; $display("FAIL mid_setup: got r0=%b we=%b wr=%0d want 0/1/13", bus.req0_ready, bus.rf_we, bus.rf_wr); end
    Clrn = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_d !== 32'h0) begin
      errors++; $display("FAIL mid_stage: got we=%b wr=%0d d=%h want 0/0/0", bus.rf_we, bus.rf_wr, bus.rf_d); end
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1 || bus.idle !== 1'b1) begin
      errors++; $display("FAIL mid_slots: got r0=%b r1=%b idle=%b want 1/1/1", bus.req0_ready, bus.req1_ready, bus.idle); end
    checks++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin errors++; $display("FAIL mid_hazard: got a=%b b=%b want 0/0", bus.hazard_a, bus.hazard_b); end
    #4;
    Clrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL mid_after k=%0d: got we=%b idle=%b want 0/1", k, bus.rf_we, bus.idle); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_contention();
    test_back_to_back();
    test_same_dest();
    test_reg_zero();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
